stall_control_unit: RTL and testbench

STALL_CONTROL_UNIT -- requirements
Module: stall_control_unit

---
 rtl/stall_control_unit.sv | 60 ++++++
 tb/tb_stall_control_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/stall_control_unit.sv
// stall_control_unit: pipeline hazard control for load-use stalls and 3-cycle multiplies.
// Define STALL_STATS_EN to enable the saturating stall_cycles counter.
module stall_control_unit (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [9:0]  if_id_rs1_2,
  input  logic        if_id_uses_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_is_mul,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_m_bubble,
  output logic        mul_done,
  output logic [15:0] stall_cycles
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t     r_state;
  logic [1:0] r_cnt;
  logic [4:0] w_rs1, w_rs2;
  logic       w_mul_stall, w_load_use;
  assign w_rs1 = if_id_rs1_2[4:0];
  assign w_rs2 = if_id_rs1_2[9:5];
  assign w_mul_stall = (r_state == IDLE && id_ex_is_mul) || (r_state == MUL && r_cnt != 2'd0);
  assign w_load_use = r_state == IDLE && !id_ex_is_mul && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      (id_ex_rd == w_rs1 || (if_id_uses_rs2 && id_ex_rd == w_rs2));
  assign pc_write     = !(w_mul_stall || w_load_use);
  assign if_id_write  = !(w_mul_stall || w_load_use);
  assign id_ex_write  = !w_mul_stall;
  assign id_ex_bubble = w_load_use;
  assign ex_m_bubble  = w_mul_stall;
  assign mul_done     = r_state == MUL && r_cnt == 2'd0;
  // The final multiply cycle returns to IDLE unconditionally so a held is_mul cannot retrigger.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else if (r_state == IDLE) begin
      r_state <= id_ex_is_mul ? MUL : IDLE;
      r_cnt   <= id_ex_is_mul ? 2'd1 : 2'd0;
    end else begin
      r_state <= (r_cnt != 2'd0) ? MUL : IDLE;
      r_cnt   <= (r_cnt != 2'd0) ? r_cnt - 2'd1 : 2'd0;
    end
  end
`ifdef STALL_STATS_EN
  logic [15:0] r_stall_cycles;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      r_stall_cycles <= 16'd0;
    else if (!pc_write && r_stall_cycles != 16'hFFFF)
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end
  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_stall_control_unit.sv
// tb_stall_control_unit: directed and random checks against a cycle-index reference model.
module tb_stall_control_unit;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [9:0]  if_id_rs1_2 = '0;
  logic        if_id_uses_rs2 = 1'b0;
  logic [4:0]  id_ex_rd = '0;
  logic        id_ex_mem_read = 1'b0;
  logic        id_ex_is_mul = 1'b0;
  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_m_bubble, mul_done;
  logic [15:0] stall_cycles;

  stall_control_unit dut (
    .clk(clk), .arst_n(arst_n), .if_id_rs1_2(if_id_rs1_2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .id_ex_is_mul(id_ex_is_mul),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_m_bubble(ex_m_bubble), .mul_done(mul_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int m_cyc, m_start, m_stalls;
  int done_q[$];
  bit log_done = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stats();
    return STATS ? 16'(m_stalls) : 16'd0;
  endfunction

  function automatic logic [15:0] ctl();
    return {10'd0, pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_m_bubble, mul_done};
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    m_start = -10;
    m_stalls = 0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic mul);
    if_id_rs1_2 = {rs2, rs1};
    if_id_uses_rs2 = u2;
    id_ex_rd = rd;
    id_ex_mem_read = mr;
    id_ex_is_mul = mul;
  endtask

  // A multiply issued at cycle m_start owns EX for cycles m_start..m_start+2.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic mr, input logic mul);
    int ph;
    logic stall_m, done, lu;
    @(negedge clk);
    drive(rs1, rs2, u2, rd, mr, mul);
    ph = m_cyc - m_start;
    if (ph >= 0 && ph <= 2) begin
      stall_m = ph < 2;
      done = ph == 2;
      lu = 1'b0;
    end else begin
      done = 1'b0;
      stall_m = mul;
      lu = !mul && mr && rd != 5'd0 && (rd == rs1 || (u2 && rd == rs2));
      if (mul) m_start = m_cyc;
    end
    #1;
    check({tag, "/ctl"}, ctl(), {10'd0, !(stall_m || lu), !(stall_m || lu), !stall_m, lu, stall_m, done});
    check({tag, "/stats"}, stall_cycles, exp_stats());
    if (log_done && mul_done) done_q.push_back(m_cyc);
    @(posedge clk);
    m_cyc++;
    if ((stall_m || lu) && m_stalls < 65535) m_stalls++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    arst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "/rst_ctl"}, ctl(), 16'b111000);
    check({tag, "/rst_stats"}, stall_cycles, 16'd0);
    #2;
    arst_n = 1'b1;
  endtask

  initial begin
    do_reset("init");
    step("idle", 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0);
    step("r31_stall", 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step("r31_after", 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
    step("r32_rd0", 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("r33_no_rs2", 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
    step("r33_rs2", 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
    step("r34_issue", 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step("r34_hold", 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step("r34_done", 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step("r34_after", 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0);
    step("r24_mul_ld", 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step("r24_hold", 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step("r20_noload", 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step("r24_idle", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    do_reset("r35");
    log_done = 1'b1;
    for (int i = 0; i < 6; i++) step("r35_b2b", 5'd1, 5'd1, 1'b0, 5'd9, 1'b0, 1'b1);
    log_done = 1'b0;
    step("r35_end", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("r35_done_count", 16'(done_q.size()), 16'd2);
    if (done_q.size() == 2) check("r35_spacing", 16'(done_q[1] - done_q[0]), 16'd3);
    if (STATS) check("r35_stats4", stall_cycles, 16'd4);
    do_reset("r36");
    step("r36_issue", 5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1);
    step("r36_hold", 5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    #1;
    check("r36_pre_done", {15'd0, mul_done}, 16'd1);
    arst_n = 1'b0;
    #1;
    check("r36_abort_ctl", ctl(), 16'b111000);
    check("r36_abort_stats", stall_cycles, 16'd0);
    arst_n = 1'b1;
    model_reset();
    step("r36_after1", 5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    step("r36_after2", 5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      step("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 5) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
